cpu_program_loader: RTL and testbench

Boot sequencer that sits directly upstream of the CPU subsystem. It accepts a byte stream over a valid/ready handshake and writes instructions into instruction memory and operands into data memory through their write ports. It then pulses the CPU start input and waits for the CPU done signal. It reports completion or a load error to the host side.

---
 rtl/cpu_program_loader_if.sv | 36 +++
 rtl/cpu_program_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_program_loader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_program_loader_if.sv
// Bus bundle for cpu_program_loader: host stream, memory write ports, CPU
// start/done handshake and host status. master = loader side, slave = environment.
interface cpu_program_loader_if #(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned ADDR_WIDTH = 3
) ();
   logic                  load_req;
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  instr_wr_en;
   logic [ADDR_WIDTH-1:0] instr_wr_addr;
   logic [DATA_WIDTH-1:0] instr_wr_data;
   logic                  data_wr_en;
   logic [ADDR_WIDTH-1:0] data_wr_addr;
   logic [7:0]            data_wr_data;
   logic                  cpu_start;
   logic                  cpu_done;
   logic                  busy;
   logic                  load_done;
   logic                  error;

   modport master (
      input  load_req, in_valid, in_data, cpu_done,
      output in_ready, instr_wr_en, instr_wr_addr, instr_wr_data,
             data_wr_en, data_wr_addr, data_wr_data,
             cpu_start, busy, load_done, error
   );

   modport slave (
      output load_req, in_valid, in_data, cpu_done,
      input  in_ready, instr_wr_en, instr_wr_addr, instr_wr_data,
             data_wr_en, data_wr_addr, data_wr_data,
             cpu_start, busy, load_done, error
   );
endinterface

// File: rtl/cpu_program_loader.sv
// Boot sequencer: takes a header + instruction/data byte stream, writes the
// instruction and data memories, pulses cpu_start and waits for cpu_done.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module cpu_program_loader #(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned MEM_DEPTH  = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rstn,
   cpu_program_loader_if.master bus
);

   localparam int unsigned CW = ADDR_WIDTH + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_INS_LO, S_INS_HI, S_DATA, S_CSUM, S_START, S_RUN, S_ERROR
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_PAYLOAD_END = S_CSUM;
`else
   localparam state_t S_PAYLOAD_END = S_START;
`endif

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [3:0]            n_i_q, n_i_d;
   logic [3:0]            n_d_q, n_d_d;
   logic [7:0]            lo_q, lo_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;
`endif

   logic                  in_ready_q, in_ready_d;
   logic                  instr_wr_en_q, instr_wr_en_d;
   logic [ADDR_WIDTH-1:0] instr_wr_addr_q, instr_wr_addr_d;
   logic [DATA_WIDTH-1:0] instr_wr_data_q, instr_wr_data_d;
   logic                  data_wr_en_q, data_wr_en_d;
   logic [ADDR_WIDTH-1:0] data_wr_addr_q, data_wr_addr_d;
   logic [7:0]            data_wr_data_q, data_wr_data_d;
   logic                  cpu_start_q, cpu_start_d;
   logic                  busy_q, busy_d;
   logic                  load_done_q, load_done_d;
   logic                  error_q, error_d;

   logic                  accept_c;
   logic                  last_ins_c;
   logic                  last_data_c;
   logic                  hdr_bad_c;

   // Byte handshake and end-of-section / header legality decodes
   always_comb begin
      accept_c    = bus.in_valid & in_ready_q;
      last_ins_c  = (32'(cnt_q) + 32'd1) == 32'(n_i_q);
      last_data_c = (32'(cnt_q) + 32'd1) == 32'(n_d_q);
      hdr_bad_c   = (bus.in_data[7:4] == 4'd0) ||
                    (32'(bus.in_data[7:4]) > MEM_DEPTH) ||
                    (32'(bus.in_data[3:0]) > MEM_DEPTH);
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      n_i_d           = n_i_q;
      n_d_d           = n_d_q;
      lo_d            = lo_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d          = csum_q;
`endif
      instr_wr_en_d   = 1'b0;
      instr_wr_addr_d = instr_wr_addr_q;
      instr_wr_data_d = instr_wr_data_q;
      data_wr_en_d    = 1'b0;
      data_wr_addr_d  = data_wr_addr_q;
      data_wr_data_d  = data_wr_data_q;
      cpu_start_d     = 1'b0;
      load_done_d     = 1'b0;

      case (state_q)
         S_IDLE, S_ERROR: begin
            if (bus.load_req) state_d = S_HDR;
         end
         S_HDR: begin
            if (accept_c) begin
               n_i_d = bus.in_data[7:4];
               n_d_d = bus.in_data[3:0];
               cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_d = bus.in_data;
`endif
               state_d = hdr_bad_c ? S_ERROR : S_INS_LO;
            end
         end
         S_INS_LO: begin
            if (accept_c) begin
               lo_d = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.in_data;
`endif
               state_d = S_INS_HI;
            end
         end
         S_INS_HI: begin
            if (accept_c) begin
               instr_wr_en_d   = 1'b1;
               instr_wr_addr_d = ADDR_WIDTH'(cnt_q);
               instr_wr_data_d = {bus.in_data[DATA_WIDTH-9:0], lo_q};
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.in_data;
`endif
               if (last_ins_c) begin
                  cnt_d   = '0;
                  state_d = (n_d_q == 4'd0) ? S_PAYLOAD_END : S_DATA;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
                  state_d = S_INS_LO;
               end
            end
         end
         S_DATA: begin
            if (accept_c) begin
               data_wr_en_d   = 1'b1;
               data_wr_addr_d = ADDR_WIDTH'(cnt_q);
               data_wr_data_d = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.in_data;
`endif
               if (last_data_c) begin
                  state_d = S_PAYLOAD_END;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
            if (accept_c) state_d = (bus.in_data == csum_q) ? S_START : S_ERROR;
`else
            state_d = S_IDLE;
`endif
         end
         S_START: begin
            cpu_start_d = 1'b1;
            state_d     = S_RUN;
         end
         S_RUN: begin
            if (bus.cpu_done) begin
               load_done_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d = (state_d == S_HDR) || (state_d == S_INS_LO) || (state_d == S_INS_HI) ||
                   (state_d == S_DATA) || (state_d == S_CSUM);
      busy_d     = (state_d != S_IDLE) && (state_d != S_ERROR);
      error_d    = (state_d == S_ERROR);
   end

   // State, counters and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         n_i_q           <= '0;
         n_d_q           <= '0;
         lo_q            <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q          <= '0;
`endif
         in_ready_q      <= 1'b0;
         instr_wr_en_q   <= 1'b0;
         instr_wr_addr_q <= '0;
         instr_wr_data_q <= '0;
         data_wr_en_q    <= 1'b0;
         data_wr_addr_q  <= '0;
         data_wr_data_q  <= '0;
         cpu_start_q     <= 1'b0;
         busy_q          <= 1'b0;
         load_done_q     <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         n_i_q           <= n_i_d;
         n_d_q           <= n_d_d;
         lo_q            <= lo_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q          <= csum_d;
`endif
         in_ready_q      <= in_ready_d;
         instr_wr_en_q   <= instr_wr_en_d;
         instr_wr_addr_q <= instr_wr_addr_d;
         instr_wr_data_q <= instr_wr_data_d;
         data_wr_en_q    <= data_wr_en_d;
         data_wr_addr_q  <= data_wr_addr_d;
         data_wr_data_q  <= data_wr_data_d;
         cpu_start_q     <= cpu_start_d;
         busy_q          <= busy_d;
         load_done_q     <= load_done_d;
         error_q         <= error_d;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.instr_wr_en   = instr_wr_en_q;
   assign bus.instr_wr_addr = instr_wr_addr_q;
   assign bus.instr_wr_data = instr_wr_data_q;
   assign bus.data_wr_en    = data_wr_en_q;
   assign bus.data_wr_addr  = data_wr_addr_q;
   assign bus.data_wr_data  = data_wr_data_q;
   assign bus.cpu_start     = cpu_start_q;
   assign bus.busy          = busy_q;
   assign bus.load_done     = load_done_q;
   assign bus.error         = error_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader: stream-level reference model compared every
// cycle, plus literal expectations on the logged memory writes.
module tb_cpu_program_loader;

   localparam int unsigned DW = 10;
   localparam int unsigned MD = 8;
   localparam int unsigned AW = 3;
`ifdef LOADER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic clk = 1'b0;
   logic rstn;

   int vectors     = 0;
   int miscompares = 0;

   cpu_program_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   cpu_program_loader #(.DATA_WIDTH(DW), .MEM_DEPTH(MD), .ADDR_WIDTH(AW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Clock
   always #5 clk = ~clk;

   // ---------------- reference model (stream position based) ----------------
   int            ph    = 0;   // 0 idle, 1 loading, 2 start pending, 3 running, 4 error
   int            pos   = 0;
   int            total = 0;
   int            ni    = 0;
   int            nd    = 0;
   logic [7:0]    mb    = '0;
   logic [7:0]    lo    = '0;
   logic [7:0]    xs    = '0;
   logic          e_in_ready = 1'b0, e_iw_en = 1'b0, e_dw_en = 1'b0;
   logic          e_start = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
   logic [AW-1:0] e_iw_addr = '0, e_dw_addr = '0;
   logic [DW-1:0] e_iw_data = '0;
   logic [7:0]    e_dw_data = '0;

   // Model: advance on each clock according to the stream rules
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ph = 0; pos = 0;
         e_in_ready = 0; e_iw_en = 0; e_dw_en = 0; e_start = 0;
         e_busy = 0; e_done = 0; e_err = 0;
         e_iw_addr = '0; e_dw_addr = '0; e_iw_data = '0; e_dw_data = '0;
      end else begin
         e_iw_en = 0; e_dw_en = 0; e_start = 0; e_done = 0;
         case (ph)
            0, 4: if (bus.load_req) begin ph = 1; pos = 0; end
            1: if (bus.in_valid && e_in_ready) begin
               mb = bus.in_data;
               if (pos == 0) begin
                  ni = int'(mb[7:4]); nd = int'(mb[3:0]); xs = mb;
                  total = 1 + 2 * ni + nd + CS;
                  if (ni == 0 || ni > int'(MD) || nd > int'(MD)) ph = 4;
               end else if (pos <= 2 * ni) begin
                  if (pos % 2 == 1) lo = mb;
                  else begin
                     e_iw_en = 1; e_iw_addr = AW'((pos - 2) / 2);
                     e_iw_data = {mb[DW-9:0], lo};
                  end
                  xs = xs ^ mb;
               end else if (pos <= 2 * ni + nd) begin
                  e_dw_en = 1; e_dw_addr = AW'(pos - 1 - 2 * ni); e_dw_data = mb;
                  xs = xs ^ mb;
               end else begin
                  if (mb != xs) ph = 4;
               end
               pos++;
               if (ph == 1 && pos == total) ph = 2;
            end
            2: begin e_start = 1; ph = 3; end
            3: if (bus.cpu_done) begin e_done = 1; ph = 0; end
            default: ph = 0;
         endcase
         e_in_ready = (ph == 1);
         e_busy     = (ph == 1) || (ph == 2) || (ph == 3);
         e_err      = (ph == 4);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Write logs for literal checks
   logic [AW-1:0] iw_addr_log[64];
   logic [DW-1:0] iw_data_log[64];
   logic [AW-1:0] dw_addr_log[64];
   logic [7:0]    dw_data_log[64];
   int iw_n = 0, dw_n = 0, start_n = 0, done_n = 0;

   // Per-cycle compare against the model, and write logging
   always @(negedge clk) begin
      chk("in_ready",  32'(bus.in_ready),      32'(e_in_ready));
      chk("iw_en",     32'(bus.instr_wr_en),   32'(e_iw_en));
      chk("iw_addr",   32'(bus.instr_wr_addr), 32'(e_iw_addr));
      chk("iw_data",   32'(bus.instr_wr_data), 32'(e_iw_data));
      chk("dw_en",     32'(bus.data_wr_en),    32'(e_dw_en));
      chk("dw_addr",   32'(bus.data_wr_addr),  32'(e_dw_addr));
      chk("dw_data",   32'(bus.data_wr_data),  32'(e_dw_data));
      chk("cpu_start", 32'(bus.cpu_start),     32'(e_start));
      chk("busy",      32'(bus.busy),          32'(e_busy));
      chk("load_done", 32'(bus.load_done),     32'(e_done));
      chk("error",     32'(bus.error),         32'(e_err));
      if (bus.instr_wr_en === 1'b1 && iw_n < 64) begin
         iw_addr_log[iw_n] = bus.instr_wr_addr; iw_data_log[iw_n] = bus.instr_wr_data; iw_n++;
      end
      if (bus.data_wr_en === 1'b1 && dw_n < 64) begin
         dw_addr_log[dw_n] = bus.data_wr_addr; dw_data_log[dw_n] = bus.data_wr_data; dw_n++;
      end
      if (bus.cpu_start === 1'b1) start_n++;
      if (bus.load_done === 1'b1) done_n++;
   end

   // ---------------- stimulus ----------------
   int gaps[6] = '{0, 2, 1, 3, 0, 1};

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_load();
      bus.load_req = 1'b1; tick(); bus.load_req = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic r;
      int   g;
      g = 0; r = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = 8'hEE;
      repeat (gap) tick();
      bus.in_valid = 1'b1; bus.in_data = b;
      do begin
         @(negedge clk); r = bus.in_ready; tick(); g++;
      end while (!r && g < 40);
      if (!r) begin
         vectors++; miscompares++;
         $display("FAIL accept_timeout: byte %0h not accepted within %0d cycles", b, g);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic send_stream(input logic [7:0] s[$], input bit use_gaps);
      logic [7:0] x;
      x = '0;
      foreach (s[i]) begin
         send_byte(s[i], use_gaps ? gaps[i % 6] : 0);
         x = x ^ s[i];
      end
      if (CS != 0) send_byte(x, 0);
   endtask

   task automatic run_cpu(input bit req_in_run);
      int g;
      g = 0;
      while (bus.cpu_start !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) begin
         vectors++; miscompares++;
         $display("FAIL start_timeout: cpu_start got 0 want 1 within 50 cycles");
      end
      tick();
      if (req_in_run) pulse_load();
      tick();
      bus.cpu_done = 1'b1; tick(); bus.cpu_done = 1'b0;
      repeat (3) tick();
   endtask

   task automatic check_t1(input string nm, input int i0, input int d0, input int s0, input int n0);
      chk({nm, "_iw_cnt"}, 32'(iw_n - i0), 32'd2);
      chk({nm, "_iw0_addr"}, 32'(iw_addr_log[i0]), 32'd0);
      chk({nm, "_iw0_data"}, 32'(iw_data_log[i0]), 32'h3A5);
      chk({nm, "_iw1_addr"}, 32'(iw_addr_log[i0+1]), 32'd1);
      chk({nm, "_iw1_data"}, 32'(iw_data_log[i0+1]), 32'h012);
      chk({nm, "_dw_cnt"}, 32'(dw_n - d0), 32'd1);
      chk({nm, "_dw0_addr"}, 32'(dw_addr_log[d0]), 32'd0);
      chk({nm, "_dw0_data"}, 32'(dw_data_log[d0]), 32'h7F);
      chk({nm, "_starts"}, 32'(start_n - s0), 32'd1);
      chk({nm, "_dones"}, 32'(done_n - n0), 32'd1);
   endtask

   logic [7:0] t1[$] = '{8'h21, 8'hA5, 8'h03, 8'h12, 8'h00, 8'h7F};

   initial begin
      int i0, d0, s0, n0;
      rstn = 1'b0;
      bus.load_req = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.cpu_done = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_error", 32'(bus.error), 32'd0);
      chk("rst_iw_data", 32'(bus.instr_wr_data), 32'd0);
      rstn = 1'b1;
      repeat (2) tick();

      // Basic load: two instructions, one data byte
      i0 = iw_n; d0 = dw_n; s0 = start_n; n0 = done_n;
      pulse_load();
      chk("t1_ready_after_req", 32'(bus.in_ready), 32'd1);
      send_stream(t1, 1'b0);
      run_cpu(1'b0);
      check_t1("t1", i0, d0, s0, n0);

      // Oversized header, then recovery with a gapped stream
      i0 = iw_n; d0 = dw_n;
      pulse_load();
      send_byte(8'h90, 0);
      repeat (2) tick();
      chk("t2_error", 32'(bus.error), 32'd1);
      chk("t2_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t2_no_iw", 32'(iw_n - i0), 32'd0);
      chk("t2_no_dw", 32'(dw_n - d0), 32'd0);
      i0 = iw_n; d0 = dw_n; s0 = start_n; n0 = done_n;
      pulse_load();
      chk("t2_err_cleared", 32'(bus.error), 32'd0);
      chk("t2_ready_again", 32'(bus.in_ready), 32'd1);
      send_stream(t1, 1'b1);
      run_cpu(1'b0);
      check_t1("t3", i0, d0, s0, n0);

      // load_req in DATA and in RUN must be ignored
      i0 = iw_n; d0 = dw_n; s0 = start_n; n0 = done_n;
      pulse_load();
      send_byte(8'h12, 0); send_byte(8'h55, 0); send_byte(8'h01, 0);
      bus.load_req = 1'b1; send_byte(8'hAA, 0); bus.load_req = 1'b0;
      send_byte(8'hBB, 0);
      if (CS != 0) send_byte(8'h12 ^ 8'h55 ^ 8'h01 ^ 8'hAA ^ 8'hBB, 0);
      run_cpu(1'b1);
      chk("t4_iw0_data", 32'(iw_data_log[i0]), 32'h155);
      chk("t4_dw_cnt", 32'(dw_n - d0), 32'd2);
      chk("t4_dw1_addr", 32'(dw_addr_log[d0+1]), 32'd1);
      chk("t4_dw1_data", 32'(dw_data_log[d0+1]), 32'hBB);
      chk("t4_starts", 32'(start_n - s0), 32'd1);
      chk("t4_dones", 32'(done_n - n0), 32'd1);
      chk("t4_idle", 32'(bus.busy), 32'd0);

      // Reset in the middle of a load
      s0 = start_n;
      pulse_load();
      send_byte(8'h21, 0); send_byte(8'hA5, 0); send_byte(8'h03, 0);
      chk("t5_wr_before_rst", 32'(bus.instr_wr_en), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("t5_iw_en", 32'(bus.instr_wr_en), 32'd0);
      chk("t5_iw_data", 32'(bus.instr_wr_data), 32'd0);
      chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      repeat (2) tick();
      rstn = 1'b1;
      repeat (5) tick();
      chk("t5_no_start", 32'(start_n - s0), 32'd0);
      chk("t5_idle", 32'(bus.busy), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      // Checksum good and bad
      s0 = start_n;
      pulse_load();
      send_byte(8'h11, 0); send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'hAA, 0);
      send_byte(8'h11 ^ 8'h05 ^ 8'h00 ^ 8'hAA, 0);
      run_cpu(1'b0);
      chk("t6_start", 32'(start_n - s0), 32'd1);
      s0 = start_n;
      pulse_load();
      send_byte(8'h11, 0); send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'hAA, 0);
      send_byte(8'h00, 0);
      repeat (4) tick();
      chk("t6_bad_error", 32'(bus.error), 32'd1);
      chk("t6_bad_no_start", 32'(start_n - s0), 32'd0);
`endif

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
